// File: rtl/dmem_byte_bridge_if.sv
// Word-request / byte-RAM bundle for dmem_byte_bridge.
// master: CPU side plus RAM read-data return (the environment).
// slave : the bridge itself.
// Signals: req_i, we_i, addr_i, wdata_i, ack_o, rdata_o, busy_o on the CPU
// side; ram_addr_o, ram_wdata_o, ram_we_o, ram_rdata_i on the RAM side.
interface dmem_byte_bridge_if #(
  parameter int unsigned N      = 32,
  parameter int unsigned L      = 8,
  parameter int unsigned A      = 32,
  parameter int unsigned MEM_AW = 12
);
  logic              req_i;
  logic              we_i;
  logic [A-1:0]      addr_i;
  logic [N-1:0]      wdata_i;
  logic              ack_o;
  logic [N-1:0]      rdata_o;
  logic              busy_o;
  logic [MEM_AW-1:0] ram_addr_o;
  logic [L-1:0]      ram_wdata_o;
  logic              ram_we_o;
  logic [L-1:0]      ram_rdata_i;

  modport master (
    output req_i, we_i, addr_i, wdata_i, ram_rdata_i,
    input  ack_o, rdata_o, busy_o, ram_addr_o, ram_wdata_o, ram_we_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, ram_rdata_i,
    output ack_o, rdata_o, busy_o, ram_addr_o, ram_wdata_o, ram_we_o
  );
endinterface

// File: rtl/dmem_byte_bridge.sv
// Word-to-byte bridge between the CPU data-memory port and a byte-wide
// synchronous RAM. Each word request becomes LANES byte accesses; reads are
// reassembled little-endian and completion is a single-cycle ack pulse.
// Ports: CLK, RST (async, active-low), bus (dmem_byte_bridge_if.slave).
// Optional feature: define DMEM_BRIDGE_WBUF_EN for a one-entry posted write
// buffer (write acked one cycle after accept, bytes drain in the background).
module dmem_byte_bridge #(
  parameter int unsigned N      = 32,
  parameter int unsigned L      = 8,
  parameter int unsigned A      = 32,
  parameter int unsigned MEM_AW = 12
) (
  input  logic              CLK,
  input  logic              RST,
  dmem_byte_bridge_if.slave bus
);

  localparam int unsigned LANES  = N / L;
  localparam int unsigned LANE_W = $clog2(LANES);
  localparam int unsigned SHW    = N - L;

  typedef enum logic [2:0] {IDLE, WR, RD, RD_LAST, ACK} state_t;

  state_t              state_q, state_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic [LANE_W-1:0]   cap_slot;
  logic [A-1:0]        addr_q, addr_d;
  logic [N-1:0]        wdata_q, wdata_d;
  logic                we_q, we_d;
  logic [SHW-1:0]      shadow_q, shadow_d;
  logic [N-1:0]        rdata_q, rdata_d;
  logic                ack_q, ack_d;
  logic                busy_q, busy_d;
  logic                ram_we_q, ram_we_d;
  logic [MEM_AW-1:0]   ram_addr_q, ram_addr_d;
  logic [L-1:0]        ram_wdata_q, ram_wdata_d;
  logic [MEM_AW-1:0]   byte_addr;

  // word*LANES + lane, silently wrapped to the RAM address width
  assign byte_addr = MEM_AW'({addr_q, lane_q});

  // State and registered outputs
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      lane_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      shadow_q    <= '0;
      rdata_q     <= '0;
      ack_q       <= 1'b0;
      busy_q      <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      shadow_q    <= shadow_d;
      rdata_q     <= rdata_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  // Next state and next output values
  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    shadow_d    = shadow_q;
    rdata_d     = rdata_q;
    ack_d       = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    // the RAM address is registered and the RAM is synchronous, so the byte
    // for lane k comes back two cycles after lane k is issued
    cap_slot    = lane_q - LANE_W'(2);

    unique case (state_q)
      IDLE: begin
        // busy_q still covers the ack cycle, so no accept can overlap it
        if (bus.req_i && !busy_q) begin
          addr_d  = bus.addr_i;
          wdata_d = bus.wdata_i;
          we_d    = bus.we_i;
          lane_d  = '0;
          state_d = bus.we_i ? WR : RD;
        end
      end
      WR: begin
        ram_we_d    = 1'b1;
        ram_addr_d  = byte_addr;
        ram_wdata_d = wdata_q[L*lane_q +: L];
        lane_d      = lane_q + LANE_W'(1);
`ifdef DMEM_BRIDGE_WBUF_EN
        if (lane_q == '0) ack_d = 1'b1;
        if (lane_q == LANE_W'(LANES - 1)) state_d = IDLE;
`else
        if (lane_q == LANE_W'(LANES - 1)) state_d = ACK;
`endif
      end
      RD: begin
        ram_addr_d = byte_addr;
        lane_d     = lane_q + LANE_W'(1);
        if (lane_q >= LANE_W'(2)) shadow_d[L*cap_slot +: L] = bus.ram_rdata_i;
        if (lane_q == LANE_W'(LANES - 1)) state_d = RD_LAST;
      end
      RD_LAST: begin
        shadow_d[L*(LANES-2) +: L] = bus.ram_rdata_i;
        state_d = ACK;
      end
      ACK: begin
        ack_d   = 1'b1;
        // top lane arrives now and goes straight into the result word
        if (!we_q) rdata_d = {bus.ram_rdata_i, shadow_q};
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_q != IDLE) || (state_d != IDLE);
  end

  assign bus.ack_o       = ack_q;
  assign bus.rdata_o     = rdata_q;
  assign bus.busy_o      = busy_q;
  assign bus.ram_we_o    = ram_we_q;
  assign bus.ram_addr_o  = ram_addr_q;
  assign bus.ram_wdata_o = ram_wdata_q;

endmodule
